// File: rtl/dfi_wrdata_sched.sv
// DFI write-data scheduler: queues granted writes and launches each burst cfg_wl
// cycles after its grant, with byte masking, completion reporting and sticky errors.
module dfi_wrdata_sched #(
   parameter int DATA_WIDTH  = 64,
   parameter int MASK_WIDTH  = DATA_WIDTH / 8,
   parameter int BURST_BEATS = 4,
   parameter int MAX_PENDING = 4,
   parameter int WL_WIDTH    = 4,
   parameter int ID_WIDTH    = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [WL_WIDTH-1:0]              cfg_wl,
   input  logic                             wr_gnt,
   input  logic [ID_WIDTH-1:0]              wr_id,
   input  logic                             wdata_valid,
   output logic                             wdata_ready,
   input  logic [DATA_WIDTH-1:0]            wdata,
   input  logic [MASK_WIDTH-1:0]            wstrb,
   input  logic                             wdata_last,
   output logic                             dfi_wrdata_en,
   output logic [DATA_WIDTH-1:0]            dfi_wrdata,
   output logic [MASK_WIDTH-1:0]            dfi_wrdata_mask,
   output logic                             wr_done_valid,
   output logic [ID_WIDTH-1:0]              wr_done_id,
   output logic [$clog2(MAX_PENDING):0]     pending_cnt,
   input  logic                             err_clr,
   output logic                             overflow_err,
   output logic                             collision_err,
   output logic                             underrun_err,
   output logic                             framing_err
);

   localparam int PTR_W  = $clog2(MAX_PENDING);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BEAT_W = $clog2(BURST_BEATS);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

   logic [ID_WIDTH-1:0] id_q [MAX_PENDING];
   logic [WL_WIDTH-1:0] cd_q [MAX_PENDING];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [CNT_W-1:0]    fifo_cnt;
   logic [0:0]          state;
   logic [BEAT_W-1:0]   beat;
   logic [ID_WIDTH-1:0] cur_id;
   logic                done_pend;

   logic [WL_WIDTH-1:0] wl_eff;
   logic [WL_WIDTH-1:0] head_cd;
   logic                due, slot0, last_slot, free, accept;
   logic [BEAT_W-1:0]   beat_idx;
   logic                underrun_ev, framing_ev, collision_ev, overflow_ev;

   assign wl_eff  = (cfg_wl < WL_WIDTH'(2)) ? WL_WIDTH'(2) : cfg_wl;
   assign head_cd = cd_q[rd_ptr];
   // A head whose countdown reached 2 owns the preload slot; below 2 it has been deferred.
   assign due     = (fifo_cnt != '0) && (head_cd <= WL_WIDTH'(2));
   assign slot0   = due && (state == ST_IDLE);

   assign wdata_ready = slot0 || (state == ST_BURST);
   assign beat_idx    = slot0 ? '0 : beat;
   assign last_slot   = wdata_ready && (beat_idx == BEAT_W'(BURST_BEATS - 1));

   // The entry frees on the edge that raises wr_done_valid, so a grant on that edge fits.
   assign free   = done_pend;
   assign accept = wr_gnt && ((pending_cnt != CNT_W'(MAX_PENDING)) || free);

   assign underrun_ev  = wdata_ready && !wdata_valid;
   assign framing_ev   = wdata_ready && wdata_valid &&
                         (wdata_last != (beat_idx == BEAT_W'(BURST_BEATS - 1)));
   assign collision_ev = slot0 && (head_cd < WL_WIDTH'(2));
   assign overflow_ev  = wr_gnt && !accept;

   // NOTE: the small entry store is reset too, so stale countdowns never look due.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MAX_PENDING; i++) begin
            id_q[i] <= '0;
            cd_q[i] <= '0;
         end
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         for (int i = 0; i < MAX_PENDING; i++)
            if (cd_q[i] != '0) cd_q[i] <= cd_q[i] - WL_WIDTH'(1);
         if (accept) begin
            id_q[wr_ptr] <= wr_id;
            cd_q[wr_ptr] <= wl_eff;
            wr_ptr       <= wr_ptr + PTR_W'(1);
         end
         if (slot0) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({accept, slot0})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_cnt <= '0;
      end else if (accept && !free) begin
         pending_cnt <= pending_cnt + CNT_W'(1);
      end else if (!accept && free) begin
         pending_cnt <= pending_cnt - CNT_W'(1);
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so same-edge reads see old values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= ST_IDLE;
         beat            <= '0;
         cur_id          <= '0;
         done_pend       <= 1'b0;
         wr_done_valid   <= 1'b0;
         wr_done_id      <= '0;
         dfi_wrdata_en   <= 1'b0;
         dfi_wrdata      <= '0;
         dfi_wrdata_mask <= '0;
      end else begin
         if (slot0) begin
            cur_id <= id_q[rd_ptr];
            state  <= ST_BURST;
            beat   <= BEAT_W'(1);
         end else if (state == ST_BURST) begin
            if (beat == BEAT_W'(BURST_BEATS - 1)) begin
               state <= ST_IDLE;
               beat  <= '0;
            end else begin
               beat <= beat + BEAT_W'(1);
            end
         end
         done_pend     <= last_slot;
         wr_done_valid <= done_pend;
         if (done_pend) wr_done_id <= cur_id;
         dfi_wrdata_en <= wdata_ready;
         if (wdata_ready && wdata_valid) begin
            dfi_wrdata      <= wdata;
            dfi_wrdata_mask <= ~wstrb;
         end else if (wdata_ready) begin
            dfi_wrdata      <= '0;
            dfi_wrdata_mask <= '1;
         end else begin
            dfi_wrdata      <= '0;
            dfi_wrdata_mask <= '0;
         end
      end
   end

   // A new event wins over err_clr in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_err  <= 1'b0;
         collision_err <= 1'b0;
         underrun_err  <= 1'b0;
         framing_err   <= 1'b0;
      end else begin
         overflow_err  <= (overflow_err  && !err_clr) || overflow_ev;
         collision_err <= (collision_err && !err_clr) || collision_ev;
         underrun_err  <= (underrun_err  && !err_clr) || underrun_ev;
         framing_err   <= (framing_err   && !err_clr) || framing_ev;
      end
   end

endmodule
